pi_window_sequencer: RTL and testbench
======================================

# pi_window_sequencer

Parametrised cartridge-side PI bus front end for the N64 cheat-cartridge design. Latches the 32-bit PI address from the multiplexed `ad` bus on ALEL/ALEH, decodes it against NUM_WIN programmable address windows, and sequences burst reads/writes onto the SST flash with an auto-incrementing halfword counter. It replaces the hard-coded per-range decoding with table-driven windows, boot-only gating, priority resolution and a defined miss response. Register-mapped peripherals (7-segment display, parallel port) sit downstream and consume `addr`, `addr_valid` and `win_hit`.

## Interface
- NUM_WIN, 4 — number of address windows, 1..8
- FLASH_AW, 19 — flash halfword address width
- INC_W, 13 — burst counter width
- SYNC_STAGES, 2 — read/write synchroniser depth, ≥2
- WIN_BASE, {NUM_WIN{32'h0}} — packed 32-bit base per window; window i = bits [32i+31:32i]
- WIN_MASK, {NUM_WIN{32'hFFF00000}} — packed 32-bit compare mask per window
- WIN_OFFSET, {NUM_WIN{FLASH_AW'h0}} — packed flash halfword offset per window
- WIN_BOOT, {NUM_WIN{1'b0}} — bit i set: window i matches only while `boot_done`=0
- MISS_DRIVE, 0 — 1: drive MISS_VALUE on reads that hit no window
- MISS_VALUE, 16'h0000 — data driven on a miss read

Ports:
- clk  in  1  system clock
- cold_reset  in  1  reset; asynchronous and active-high
- ad_in  in  16  sampled PI `ad` bus
- ad_out  out  16  PI data to drive
- ad_oe  out  1  tristate enable for ad_out
- alel, aleh  in  1 each  PI address latch enables
- read, write  in  1 each  PI strobes, active-low, asynchronous to clk
- boot_done  in  1  set by register block after boot; gates WIN_BOOT windows
- sst  out  FLASH_AW  flash address
- sst_ce, sst_oe  out  1 each  flash chip/output enable, active-low
- addr  out  32  latched PI address
- addr_valid  out  1  high once the upper half is latched
- win_hit  out  NUM_WIN  one-hot resolved window, 0 on miss
- busy  out  1  high in ACTIVE or RECOVER

## Operation
- Reset values: ad_out=0, ad_oe=0, sst=0, sst_ce=1, sst_oe=1, addr=0, addr_valid=0, win_hit=0, busy=0, burst counter=0, state IDLE, synchroniser stages=1.
- Address capture: alel&!aleh → addr[15:0]←ad_in, addr_valid←0, counter←0. alel&aleh → addr[31:16]←ad_in, addr_valid←1.
- Match i: ((addr & mask_i) == (base_i & mask_i)) && addr_valid && !(WIN_BOOT[i] && boot_done). Lowest matching index wins; win_hit is one-hot.
- Flash address: sst = offset_i + (addr & ~mask_i)[FLASH_AW:1] + counter, truncated modulo 2^FLASH_AW.
- rd_l/wr_l = synchronised read/write low. Read takes priority; a simultaneous write is ignored for that access.
- FSM:
  - IDLE: on rd_l or wr_l → ACTIVE (latch sst).
  - ACTIVE: sst_ce=0 if a window hits; sst_oe=0 only for read hits. On a miss read with MISS_DRIVE=1: ad_oe=1, ad_out=MISS_VALUE. When both strobes are synchronised high → RECOVER.
  - RECOVER: counter+1 (wraps at 2^INC_W), outputs deasserted → IDLE.
- ALE assertion in any state forces IDLE next cycle, deasserts ce/oe/ad_oe and applies the capture rules. ALE wins over a same-cycle strobe edge.
- Writes to a miss window produce no flash activity but still advance the counter.

## Timing
- Strobe fall to sst_ce/sst_oe low: SYNC_STAGES+1 clk cycles.
- Strobe rise to ce/oe high: SYNC_STAGES+1 cycles; counter increments in the RECOVER cycle; the next sst value is valid before the next strobe is accepted.
- addr/win_hit update 1 cycle after ALE sampled; win_hit registered.
- cold_reset asserted mid-access: ce/oe high and ad_oe low immediately (async); release resumes in IDLE with addr_valid=0.
- boot_done rising mid-burst: win_hit re-evaluates next cycle; ACTIVE access to a now-disabled window drops ce/oe next cycle.

## Test plan
- WIN_BASE0=32'h10000000, MASK=32'hFFF00000, OFFSET 0; ALE 32'h10000040, 3 reads → sst 19'h20,21,22, each ce/oe low SYNC_STAGES+1 cycles after strobe fall; counter=3.
- Windows 0 and 1 both matching 32'h1EC00000 → win_hit=2'b01, sst uses offset_0.
- WIN_BOOT[0]=1; read to window 0 with boot_done=0 → ce low; with boot_done=1 → win_hit=0, MISS_DRIVE=1 gives ad_oe=1, ad_out=MISS_VALUE, ce stays high.
- INC_W=2 with 5 reads → sst offsets 0,1,2,3,0 (wrap).
- read and write low together → sst_oe=0 (read), no write; ALE pulse during ACTIVE → IDLE next cycle, ce high, counter 0.
- cold_reset pulsed mid-read → sst_ce=1, sst_oe=1, ad_oe=0 without waiting for clk; addr_valid=0 after release.

Source files
------------

// File: rtl/pi_window_sequencer.sv
// ---------------------------------------------------------------------------
// pi_window_sequencer
//   Cartridge-side PI bus front end. Captures the 32-bit PI address from the
//   multiplexed ad bus on ALEL/ALEH and decodes it against NUM_WIN
//   programmable windows. Each window can be restricted to the boot phase.
//   Read/write bursts are sequenced onto the SST flash with an
//   auto-incrementing halfword counter.
//
// Ports
//   clk         system clock
//   cold_reset  asynchronous active-high reset
//   ad_in       sampled PI ad bus
//   ad_out      PI data to drive (miss response only)
//   ad_oe       tristate enable for ad_out
//   alel, aleh  PI address latch enables
//   read, write active-low PI strobes, asynchronous to clk
//   boot_done   disables boot-only windows once set
//   sst         flash halfword address
//   sst_ce      flash chip enable, active-low
//   sst_oe      flash output enable, active-low
//   addr        latched PI address
//   addr_valid  high once the upper half of the address is latched
//   win_hit     one-hot resolved window, 0 on a miss
//   busy        high while an access is ACTIVE or in RECOVER
// ---------------------------------------------------------------------------

// Per-window compare and flash base computation.
module pi_win_match #(
   parameter int          FLASH_AW = 19,
   parameter logic [31:0] BASE     = 32'h0,
   parameter logic [31:0] MASK     = 32'hFFF00000,
   parameter logic [FLASH_AW-1:0] OFFSET = '0,
   parameter bit          BOOT     = 1'b0
) (
   input  logic [31:0]         addr,
   input  logic                addr_valid,
   input  logic                boot_done,
   output logic                match,
   output logic [FLASH_AW-1:0] fbase
);
   assign match = ((addr & MASK) == (BASE & MASK)) && addr_valid
                  && !(BOOT && boot_done);

   // Halfword index of the address within the window, relocated by OFFSET.
   // The sum wraps modulo 2^FLASH_AW.
   assign fbase = OFFSET + (addr[FLASH_AW:1] & ~MASK[FLASH_AW:1]);
endmodule

module pi_window_sequencer #(
   parameter int NUM_WIN     = 4,
   parameter int FLASH_AW    = 19,
   parameter int INC_W       = 13,
   parameter int SYNC_STAGES = 2,
   parameter logic [32*NUM_WIN-1:0]       WIN_BASE   = {NUM_WIN{32'h0}},
   parameter logic [32*NUM_WIN-1:0]       WIN_MASK   = {NUM_WIN{32'hFFF00000}},
   parameter logic [FLASH_AW*NUM_WIN-1:0] WIN_OFFSET = '0,
   parameter logic [NUM_WIN-1:0]          WIN_BOOT   = '0,
   parameter bit          MISS_DRIVE = 1'b0,
   parameter logic [15:0] MISS_VALUE = 16'h0000
) (
   input  logic                clk,
   input  logic                cold_reset,
   input  logic [15:0]         ad_in,
   output logic [15:0]         ad_out,
   output logic                ad_oe,
   input  logic                alel,
   input  logic                aleh,
   input  logic                read,
   input  logic                write,
   input  logic                boot_done,
   output logic [FLASH_AW-1:0] sst,
   output logic                sst_ce,
   output logic                sst_oe,
   output logic [31:0]         addr,
   output logic                addr_valid,
   output logic [NUM_WIN-1:0]  win_hit,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;

   state_t                              state;
   logic [INC_W-1:0]                    cnt;
   logic                                is_rd;
   logic [FLASH_AW-1:0]                 fbase_q;
   logic [SYNC_STAGES-1:0]              rd_sync, wr_sync;
   logic                                rd_l, wr_l;

   logic [31:0]                         addr_d;
   logic                                valid_d;
   logic [NUM_WIN-1:0]                  match;
   logic [NUM_WIN-1:0][FLASH_AW-1:0]    fbase;
   logic [NUM_WIN-1:0]                  hit_d;
   logic [FLASH_AW-1:0]                 fbase_d;
   logic                                hit;
   logic                                rd_acc;
   logic                                drive_miss;
   logic [FLASH_AW-1:0]                 sst_calc;

   // -----------------------------------------------------------------------
   // Strobe synchronisers; idle (high) out of reset.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge cold_reset) begin
      if (cold_reset) begin
         rd_sync <= '1;
         wr_sync <= '1;
      end else begin
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], read};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], write};
      end
   end

   assign rd_l = !rd_sync[SYNC_STAGES-1];
   assign wr_l = !wr_sync[SYNC_STAGES-1];

   // -----------------------------------------------------------------------
   // Next-state address. Windows are matched against this value so that
   // addr and win_hit change on the same edge.
   // -----------------------------------------------------------------------
   always_comb begin
      addr_d  = addr;
      valid_d = addr_valid;
      if (alel && !aleh) begin
         addr_d[15:0] = ad_in;
         valid_d      = 1'b0;
      end else if (alel && aleh) begin
         addr_d[31:16] = ad_in;
         valid_d       = 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
      pi_win_match #(
         .FLASH_AW (FLASH_AW),
         .BASE     (WIN_BASE[32*i +: 32]),
         .MASK     (WIN_MASK[32*i +: 32]),
         .OFFSET   (WIN_OFFSET[FLASH_AW*i +: FLASH_AW]),
         .BOOT     (WIN_BOOT[i])
      ) u_win (
         .addr       (addr_d),
         .addr_valid (valid_d),
         .boot_done  (boot_done),
         .match      (match[i]),
         .fbase      (fbase[i])
      );
   end

   // Lowest-index match wins.
   always_comb begin
      logic found;
      hit_d   = '0;
      fbase_d = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_WIN; i++) begin
         if (match[i] && !found) begin
            hit_d[i] = 1'b1;
            fbase_d  = fbase[i];
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge cold_reset) begin
      if (cold_reset) begin
         addr       <= '0;
         addr_valid <= 1'b0;
         win_hit    <= '0;
         fbase_q    <= '0;
      end else begin
         addr       <= addr_d;
         addr_valid <= valid_d;
         win_hit    <= hit_d;
         fbase_q    <= fbase_d;
      end
   end

   // -----------------------------------------------------------------------
   // Access sequencer
   // -----------------------------------------------------------------------
   assign hit        = |win_hit;
   // Access type is decided when leaving IDLE (read wins) and held after.
   assign rd_acc     = (state == IDLE) ? rd_l : is_rd;
   assign drive_miss = !hit && rd_acc && MISS_DRIVE;
   // On a miss fbase_q is 0, so sst just tracks the counter.
   assign sst_calc   = fbase_q + FLASH_AW'(cnt);

   always_ff @(posedge clk or posedge cold_reset) begin
      if (cold_reset) begin
         state  <= IDLE;
         cnt    <= '0;
         is_rd  <= 1'b0;
         sst    <= '0;
         sst_ce <= 1'b1;
         sst_oe <= 1'b1;
         ad_oe  <= 1'b0;
         ad_out <= '0;
         busy   <= 1'b0;
      end else if (alel) begin
         // Address phase aborts any access in flight.
         state  <= IDLE;
         sst_ce <= 1'b1;
         sst_oe <= 1'b1;
         ad_oe  <= 1'b0;
         ad_out <= '0;
         busy   <= 1'b0;
         if (!aleh) cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Keep sst tracking so it is valid before the strobe lands.
               sst <= sst_calc;
               if (rd_l || wr_l) begin
                  state  <= ACTIVE;
                  busy   <= 1'b1;
                  is_rd  <= rd_l;
                  sst_ce <= !hit;
                  sst_oe <= !(hit && rd_l);
                  ad_oe  <= drive_miss;
                  ad_out <= drive_miss ? MISS_VALUE : 16'h0000;
               end
            end
            ACTIVE: begin
               if (!rd_l && !wr_l) begin
                  state  <= RECOVER;
                  sst_ce <= 1'b1;
                  sst_oe <= 1'b1;
                  ad_oe  <= 1'b0;
                  ad_out <= '0;
               end else begin
                  // Re-evaluate each cycle so a window disabled by
                  // boot_done mid-access releases the flash.
                  sst_ce <= !hit;
                  sst_oe <= !(hit && is_rd);
                  ad_oe  <= drive_miss;
                  ad_out <= drive_miss ? MISS_VALUE : 16'h0000;
               end
            end
            RECOVER: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= cnt + INC_W'(1);
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               sst_ce <= 1'b1;
               sst_oe <= 1'b1;
               ad_oe  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pi_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pi_window_sequencer
//   Directed bench. Four windows:
//     0: 1000_0000 / FFF0_0000, offset 0
//     1: 1EC0_0000 / FFF0_0000, offset 1_0000
//     2: 1E00_0000 / FF00_0000, offset 2_0000  (overlaps window 1)
//     3: 1FC0_0000 / FFFF_0000, offset 3_0000, boot-only
//   Miss reads drive DEAD; INC_W=2 so bursts wrap after four halfwords.
// ---------------------------------------------------------------------------
module tb_pi_window_sequencer;

   localparam int NW = 4;
   localparam int AW = 19;

   logic          clk = 1'b0;
   logic          cold_reset;
   logic [15:0]   ad_in;
   logic [15:0]   ad_out;
   logic          ad_oe;
   logic          alel, aleh, read, write, boot_done;
   logic [AW-1:0] sst;
   logic          sst_ce, sst_oe;
   logic [31:0]   addr;
   logic          addr_valid;
   logic [NW-1:0] win_hit;
   logic          busy;

   pi_window_sequencer #(
      .NUM_WIN     (NW),
      .FLASH_AW    (AW),
      .INC_W       (2),
      .SYNC_STAGES (2),
      .WIN_BASE    ({32'h1FC00000, 32'h1E000000, 32'h1EC00000, 32'h10000000}),
      .WIN_MASK    ({32'hFFFF0000, 32'hFF000000, 32'hFFF00000, 32'hFFF00000}),
      .WIN_OFFSET  ({19'h30000, 19'h20000, 19'h10000, 19'h00000}),
      .WIN_BOOT    (4'b1000),
      .MISS_DRIVE  (1'b1),
      .MISS_VALUE  (16'hDEAD)
   ) dut (
      .clk        (clk),
      .cold_reset (cold_reset),
      .ad_in      (ad_in),
      .ad_out     (ad_out),
      .ad_oe      (ad_oe),
      .alel       (alel),
      .aleh       (aleh),
      .read       (read),
      .write      (write),
      .boot_done  (boot_done),
      .sst        (sst),
      .sst_ce     (sst_ce),
      .sst_oe     (sst_oe),
      .addr       (addr),
      .addr_valid (addr_valid),
      .win_hit    (win_hit),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Values observed during the ACTIVE phase of the last access.
   logic [AW-1:0] o_sst;
   logic          o_ce, o_oe, o_aoe;
   logic [15:0]   o_aout;
   logic [NW-1:0] o_hit;
   int            lat, rel_lat;

   typedef struct {
      logic [31:0]   a;
      logic          rd;
      logic          wr;
      logic          boot;
      logic [NW-1:0] hit;
      logic [AW-1:0] sst;
      logic          ce;
      logic          oe;
      logic          aoe;
      logic [15:0]   aout;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic latch(input logic [31:0] a);
      @(negedge clk); alel = 1'b1; aleh = 1'b0; ad_in = a[15:0];
      @(negedge clk); aleh = 1'b1; ad_in = a[31:16];
      @(negedge clk); alel = 1'b0; aleh = 1'b0; ad_in = 16'h0;
   endtask

   // Full strobe cycle: assert, wait for ACTIVE, capture, release, wait idle.
   task automatic access(input logic rd, input logic wr);
      int k;
      @(negedge clk); read = !rd; write = !wr;
      k = 0;
      while (!busy && k < 10) begin @(negedge clk); k++; end
      lat = k;
      if (!busy) chk("access_start_timeout", 32'(busy), 32'd1);
      o_sst = sst; o_ce = sst_ce; o_oe = sst_oe;
      o_aoe = ad_oe; o_aout = ad_out; o_hit = win_hit;
      read = 1'b1; write = 1'b1;
      k = 0;
      while (!(sst_ce && sst_oe && !ad_oe) && k < 10) begin @(negedge clk); k++; end
      rel_lat = k;
      k = 0;
      while (busy && k < 10) begin @(negedge clk); k++; end
      if (busy) chk("access_end_timeout", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_busy();
      int k;
      k = 0;
      while (!busy && k < 10) begin @(negedge clk); k++; end
      if (!busy) chk("wait_busy_timeout", 32'(busy), 32'd1);
   endtask

   initial begin
      //           addr          rd    wr    boot  hit      sst        ce    oe    aoe   aout
      vecs[0] = '{32'h10000040, 1'b1, 1'b0, 1'b0, 4'b0001, 19'h00020, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[1] = '{32'h10000040, 1'b0, 1'b1, 1'b0, 4'b0001, 19'h00020, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[2] = '{32'h1EC00000, 1'b1, 1'b0, 1'b0, 4'b0010, 19'h10000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[3] = '{32'h1E000100, 1'b1, 1'b0, 1'b0, 4'b0100, 19'h20080, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[4] = '{32'h1FC00010, 1'b1, 1'b0, 1'b0, 4'b1000, 19'h30008, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[5] = '{32'h1FC00010, 1'b1, 1'b0, 1'b1, 4'b0000, 19'h00000, 1'b1, 1'b1, 1'b1, 16'hDEAD};
      vecs[6] = '{32'h1FC00010, 1'b0, 1'b1, 1'b1, 4'b0000, 19'h00000, 1'b1, 1'b1, 1'b0, 16'h0000};
      vecs[7] = '{32'h20000000, 1'b1, 1'b0, 1'b0, 4'b0000, 19'h00000, 1'b1, 1'b1, 1'b1, 16'hDEAD};
      vecs[8] = '{32'h10000040, 1'b1, 1'b1, 1'b0, 4'b0001, 19'h00020, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[9] = '{32'h1E0FFFFE, 1'b1, 1'b0, 1'b0, 4'b0100, 19'h1FFFF, 1'b0, 1'b0, 1'b0, 16'h0000};

      cold_reset = 1'b1; ad_in = 16'h0; alel = 1'b0; aleh = 1'b0;
      read = 1'b1; write = 1'b1; boot_done = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_ad_out", 32'(ad_out), 32'h0);
      chk("rst_ad_oe", 32'(ad_oe), 32'h0);
      chk("rst_sst", 32'(sst), 32'h0);
      chk("rst_sst_ce", 32'(sst_ce), 32'h1);
      chk("rst_sst_oe", 32'(sst_oe), 32'h1);
      chk("rst_addr", addr, 32'h0);
      chk("rst_addr_valid", 32'(addr_valid), 32'h0);
      chk("rst_win_hit", 32'(win_hit), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      cold_reset = 1'b0;

      // Table: one fresh address latch and one access per vector.
      for (int v = 0; v < 10; v++) begin
         boot_done = vecs[v].boot;
         latch(vecs[v].a);
         chk($sformatf("v%0d_addr", v), addr, vecs[v].a);
         chk($sformatf("v%0d_addr_valid", v), 32'(addr_valid), 32'h1);
         access(vecs[v].rd, vecs[v].wr);
         chk($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
         chk($sformatf("v%0d_win_hit", v), 32'(o_hit), 32'(vecs[v].hit));
         chk($sformatf("v%0d_sst", v), 32'(o_sst), 32'(vecs[v].sst));
         chk($sformatf("v%0d_sst_ce", v), 32'(o_ce), 32'(vecs[v].ce));
         chk($sformatf("v%0d_sst_oe", v), 32'(o_oe), 32'(vecs[v].oe));
         chk($sformatf("v%0d_ad_oe", v), 32'(o_aoe), 32'(vecs[v].aoe));
         chk($sformatf("v%0d_ad_out", v), 32'(o_aout), 32'(vecs[v].aout));
      end
      boot_done = 1'b0;

      // Burst of five reads: counter advances and wraps at 4.
      latch(32'h10000040);
      for (int n = 0; n < 5; n++) begin
         logic [AW-1:0] exp_sst;
         exp_sst = 19'h20 + 19'(n % 4);
         access(1'b1, 1'b0);
         chk($sformatf("burst%0d_sst", n), 32'(o_sst), 32'(exp_sst));
         chk($sformatf("burst%0d_ce", n), 32'(o_ce), 32'h0);
         chk($sformatf("burst%0d_release", n), 32'(rel_lat), 32'd3);
         if (n == 2) chk("burst_idle_sst_after3", 32'(sst), 32'h23);
      end

      // ALE during ACTIVE aborts the access and clears the counter.
      latch(32'h10000040);
      access(1'b1, 1'b0);
      access(1'b1, 1'b0);
      @(negedge clk); read = 1'b0;
      wait_busy();
      chk("ale_pre_ce", 32'(sst_ce), 32'h0);
      alel = 1'b1; aleh = 1'b0; ad_in = 16'h0040; read = 1'b1;
      @(negedge clk);
      chk("ale_busy", 32'(busy), 32'h0);
      chk("ale_ce", 32'(sst_ce), 32'h1);
      chk("ale_oe", 32'(sst_oe), 32'h1);
      chk("ale_addr_valid", 32'(addr_valid), 32'h0);
      aleh = 1'b1; ad_in = 16'h1000;
      @(negedge clk); alel = 1'b0; aleh = 1'b0; ad_in = 16'h0;
      access(1'b1, 1'b0);
      chk("ale_counter_cleared_sst", 32'(o_sst), 32'h20);

      // boot_done rising while a boot-only window is being read.
      latch(32'h1FC00010);
      @(negedge clk); read = 1'b0;
      wait_busy();
      chk("boot_pre_ce", 32'(sst_ce), 32'h0);
      boot_done = 1'b1;
      @(negedge clk);
      chk("boot_win_hit_cleared", 32'(win_hit), 32'h0);
      chk("boot_ce_still_low", 32'(sst_ce), 32'h0);
      @(negedge clk);
      chk("boot_ce_dropped", 32'(sst_ce), 32'h1);
      chk("boot_oe_dropped", 32'(sst_oe), 32'h1);
      chk("boot_miss_ad_oe", 32'(ad_oe), 32'h1);
      chk("boot_miss_ad_out", 32'(ad_out), 32'hDEAD);
      read = 1'b1;
      repeat (6) @(negedge clk);
      chk("boot_idle", 32'(busy), 32'h0);
      boot_done = 1'b0;

      // cold_reset mid-read acts without a clock edge.
      latch(32'h10000040);
      @(negedge clk); read = 1'b0;
      wait_busy();
      chk("crst_pre_ce", 32'(sst_ce), 32'h0);
      #2 cold_reset = 1'b1;
      #1;
      chk("crst_ce_async", 32'(sst_ce), 32'h1);
      chk("crst_oe_async", 32'(sst_oe), 32'h1);
      chk("crst_ad_oe_async", 32'(ad_oe), 32'h0);
      @(negedge clk); read = 1'b1; cold_reset = 1'b0;
      @(negedge clk);
      chk("crst_addr_valid", 32'(addr_valid), 32'h0);
      chk("crst_busy", 32'(busy), 32'h0);
      chk("crst_ce_after", 32'(sst_ce), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
